// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the MIPS fetch front end.
// Entries pair an instruction with the address of its successor.
package mips_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, head readable combinationally; clear empties it in one cycle.
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dat   = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_dat;
  end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch PC owner and prefetch buffer between instruction memory and IF/ID.
// Issue is credit-limited so every in-flight response already has a queue slot.
module fetch_prefetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc_plus4
);
  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUT + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [OW-1:0]   r_drop_cnt;

  logic            w_grant, w_resp, w_q_push, w_q_pop;
  logic            w_q_full, w_q_empty, w_tag_full, w_tag_empty;
  logic [QCW-1:0]  w_q_count;
  logic [OW-1:0]   w_tag_count;
  logic [XLEN-1:0] w_tag_dat;
  logic [31:0]     w_used;
  fetch_entry_t    w_q_in, w_q_head;
  logic            w_unused_ok;

  // Outstanding requests are exactly the tags still waiting for a response.
  assign w_used   = 32'(w_q_count) + 32'(w_tag_count) - 32'(r_drop_cnt);
  assign imem_req = rst & ~redirect & ~w_tag_full & (w_used < 32'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_grant  = imem_req & imem_gnt;
  assign w_resp   = imem_rvalid & ~w_tag_empty;

  assign w_q_push = w_resp & (r_drop_cnt == '0) & ~redirect;
  assign w_q_pop  = out_valid & ~stall & ~redirect;
  assign w_q_in   = '{instr: imem_rdata, pc_plus4: w_tag_dat + 32'd4};

  assign out_valid    = ~w_q_empty;
  assign out_instr    = out_valid ? w_q_head.instr : NOP_INSTR;
  assign out_pc_plus4 = out_valid ? w_q_head.pc_plus4 : '0;
  assign w_unused_ok  = &{1'b0, redirect_pc[1:0]};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_q_push),
    .i_dat   (w_q_in),
    .i_pop   (w_q_pop),
    .i_clear (redirect),
    .o_dat   (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_grant),
    .i_dat   (r_fetch_pc),
    .i_pop   (w_resp),
    .i_clear (1'b0),
    .o_dat   (w_tag_dat),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      r_drop_cnt <= w_tag_count - OW'(w_resp);
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_resp && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst) !(imem_rvalid && w_tag_empty));
  a_no_overflow:    assert property (@(posedge clk) disable iff (!rst) !(w_q_push && w_q_full && !w_q_pop));
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench: in-order variable-latency memory plus an epoch-based fetch model.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk, rst, stall, redirect, imem_req, imem_gnt, imem_rvalid, out_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, out_instr, out_pc_plus4;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_plus4(out_pc_plus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int epoch;} infl_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;

  int vectors = 0, miscompares = 0, cyc = 0;
  int lat_min = 1, lat_max = 1, gnt_pct = 100;
  infl_t infl_q[$];
  mreq_t mem_q[$];
  logic [63:0] out_q[$];
  logic [31:0] m_pc;
  int epoch;
  logic [97:0] obs_vec, exp_vec;
  logic obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic model_reset();
    out_q.delete(); infl_q.delete(); mem_q.delete();
    m_pc = RESET_PC; epoch = 0;
  endtask

  // One cycle: memory drives, snapshot expected/observed, advance model and clock.
  task automatic tick();
    int live;
    logic exp_req, exp_valid;
    logic [63:0] head;
    infl_t e;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    live = 0;
    foreach (infl_q[i]) if (infl_q[i].epoch == epoch) live++;
    exp_req   = !redirect && infl_q.size() < MAX_OUT && (out_q.size() + live) < DEPTH;
    exp_valid = out_q.size() > 0;
    head      = exp_valid ? out_q[0] : 64'h0;
    exp_vec = {exp_req, m_pc, exp_valid, head};
    obs_vec = {imem_req, imem_addr, out_valid, out_instr, out_pc_plus4};
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = out_valid; obs_pc4 = out_pc_plus4;
    if (exp_valid && !stall && !redirect) void'(out_q.pop_front());
    if (imem_rvalid && infl_q.size() > 0) begin
      e = infl_q.pop_front();
      if (!redirect && e.epoch == epoch) out_q.push_back({mem_word(e.addr), e.addr + 32'd4});
    end
    if (exp_req && imem_gnt) begin
      infl_q.push_back('{addr: m_pc, epoch: epoch});
      m_pc = m_pc + 32'd4;
    end
    if (redirect) begin
      out_q.delete(); epoch++;
      m_pc = {redirect_pc[31:2], 2'b00};
    end
    if (imem_req && imem_gnt)
      mem_q.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
    if (imem_rvalid) void'(mem_q.pop_front());
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if ({imem_req, imem_addr, out_valid, out_instr, out_pc_plus4} !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0}) begin
        miscompares++;
        $display("FAIL reset[%0d] got req=%b addr=%h v=%b instr=%h pc4=%h, want all zero", k,
                 imem_req, imem_addr, out_valid, out_instr, out_pc_plus4);
      end
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    int n = 0, nvalid = 0;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    for (int k = 0; k < 30; k++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL stream cyc=%0d got %h want %h", cyc, obs_vec, exp_vec);
      end
      if (obs_req && n < 3) begin
        vectors++;
        if (obs_addr !== 32'(n * 4)) begin
          miscompares++; $display("FAIL stream_addr%0d got %h want %h", n, obs_addr, n * 4);
        end
        n++;
      end
      if (k >= 5 && obs_valid) nvalid++;
    end
    vectors++;
    if (nvalid != 25) begin
      miscompares++; $display("FAIL throughput got %0d valid cycles want 25", nvalid);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL stall cyc=%0d got %h want %h", cyc, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL stall_full got req=%b valid=%b want req=0 valid=1", imem_req, out_valid);
    end
    stall = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL drain cyc=%0d got %h want %h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_latency3();
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    for (int k = 0; k < 30; k++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec || mem_q.size() > MAX_OUT) begin
        miscompares++;
        $display("FAIL lat3 cyc=%0d inflight=%0d got %h want %h", cyc, mem_q.size(), obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_redirect();
    int waited = 0;
    logic seen_req = 1'b0, seen_valid = 1'b0;
    while (mem_q.size() != 2 && waited < 20) begin tick(); waited++; end
    vectors++;
    if (mem_q.size() != 2) begin
      miscompares++; $display("FAIL redir_setup got %0d outstanding want 2", mem_q.size());
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL redir cyc=%0d got %h want %h", cyc, obs_vec, exp_vec);
      end
      if (obs_req && !seen_req) begin
        seen_req = 1'b1; vectors++;
        if (obs_addr !== 32'h40) begin
          miscompares++; $display("FAIL redir_addr got %h want 00000040", obs_addr);
        end
      end
      if (obs_valid && !seen_valid) begin
        seen_valid = 1'b1; vectors++;
        if (obs_pc4 !== 32'h44) begin
          miscompares++; $display("FAIL redir_pc4 got %h want 00000044", obs_pc4);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    logic seen_valid = 1'b0;
    lat_min = 1; lat_max = 1;
    while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && waited < 20) begin tick(); waited++; end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    vectors++;
    if (imem_rvalid !== 1'b1) begin
      miscompares++; $display("FAIL b2b_setup got rvalid=%b want 1", imem_rvalid);
    end
    redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec || (obs_valid && (obs_pc4 < 32'h204 || obs_pc4 >= 32'h300))) begin
        miscompares++; $display("FAIL b2b cyc=%0d got %h want %h", cyc, obs_vec, exp_vec);
      end
      if (obs_valid && !seen_valid) begin
        seen_valid = 1'b1; vectors++;
        if (obs_pc4 !== 32'h204) begin
          miscompares++; $display("FAIL b2b_first got %h want 00000204", obs_pc4);
        end
      end
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4; gnt_pct = 75;
    for (int k = 0; k < 600; k++) begin
      stall    = ($urandom_range(99) < 30);
      redirect = ($urandom_range(99) < 4);
      redirect_pc = {20'h0, 12'($urandom)};
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL random cyc=%0d got %h want %h", cyc, obs_vec, exp_vec);
      end
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int waited = 0;
    lat_min = 2; lat_max = 2; gnt_pct = 100;
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    redirect = 1'b0; stall = 1'b1;
    while (!(out_q.size() > 0 && mem_q.size() == 1) && waited < 30) begin tick(); waited++; end
    vectors++;
    if (!(out_q.size() > 0 && mem_q.size() == 1)) begin
      miscompares++; $display("FAIL rstmid_setup got q=%0d inflight=%0d want q>0 inflight=1", out_q.size(), mem_q.size());
    end
    rst = 1'b0; imem_rvalid = 1'b0;
    #1;
    vectors++;
    if ({imem_req, imem_addr, out_valid, out_instr, out_pc_plus4} !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL rstmid got req=%b addr=%h v=%b instr=%h pc4=%h, want req=0 addr=%h rest 0",
               imem_req, imem_addr, out_valid, out_instr, out_pc_plus4, RESET_PC);
    end
    model_reset();
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec || (k == 0 && (obs_req !== 1'b1 || obs_addr !== RESET_PC))) begin
        miscompares++; $display("FAIL restart cyc=%0d got %h want %h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_latency3();
    test_redirect();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Fetch-stage front end of the pipelined MIPS core. Sits between a variable-latency instruction memory and the IF/ID pipeline register.
- Owns the fetch PC and issues in-order word requests to instruction memory. Buffers returned instructions in a small queue.
- Presents {instr, pc+4} to IF/ID. Holds output under the ID-stage hazard stall.
- On a branch/jump redirect, flushes buffered words and discards in-flight responses.

Parameters:
- DEPTH, 4, queue entries (power of two, ≥2).
- MAX_OUT, 2, maximum outstanding memory requests (≤DEPTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stall  in  1  ID hazard; when 1, head entry is not consumed.
- redirect  in  1  taken branch or jump resolved in ID.
- redirect_pc  in  32  branch/jump target.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned request address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  response instruction.
- out_valid  out  1  head entry valid toward IF/ID.
- out_instr  out  32  head instruction; 32'h0 (nop) when out_valid=0.
- out_pc_plus4  out  32  head entry address + 4.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low.
- Reset (rst=0), applied immediately:
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - imem_req=0; imem_addr=RESET_PC; out_valid=0; out_instr=0; out_pc_plus4=0.
  - First request may assert in the first cycle after rst rises.
- Issue:
  - imem_req = rst & ~redirect & (outstanding < MAX_OUT) & (count + outstanding − drop_cnt < DEPTH).
  - Credits reserve queue space, so a response is never dropped for lack of room.
- Grant: imem_req & imem_gnt → fetch_pc += 4 (wraps modulo 2^32); outstanding += 1. The address is pushed to a tag FIFO (depth MAX_OUT) so each response is paired with its PC.
- Response: imem_rvalid → outstanding −= 1; tag FIFO pops.
  - If drop_cnt > 0: drop_cnt −= 1 and the data is discarded.
  - Else: push {rdata, tag+4} into the queue.
  - A simultaneous grant and response update outstanding by net 0.
- Consume: out_valid & ~stall & ~redirect → pop the head.
  - Output is the head entry, combinational from queue storage.
  - Zero-latency bypass is not required: a response appears at the output the cycle after it is received.
- Redirect (highest priority):
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - Queue cleared; no pop that cycle.
  - drop_cnt ← outstanding − imem_rvalid. Any response arriving in the redirect cycle is also discarded.
  - Tag FIFO is not cleared; it drains with the dropped responses.
  - Back-to-back redirects recompute drop_cnt the same way each time.
- Full/empty:
  - Empty → out_valid=0 regardless of stall.
  - Full with stall held → imem_req=0 until a pop frees a credit.
  - Push and pop in the same cycle while full is legal, because space was credited.
- Error cases:
  - imem_rvalid with outstanding=0 is ignored and flagged by a simulation assertion.
  - redirect_pc[1:0]≠0 is truncated.
- rst asserted mid-transaction clears all counters. The memory side is also reset by the same rst, so no stale response is expected afterwards.

Decomposition:
- Package mips_fetch_pkg:
  - XLEN=32, NOP_INSTR=32'h0, default RESET_PC.
  - Packed struct fetch_entry_t {instr[31:0], pc_plus4[31:0]}.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/clear, full/empty/count).
  - Instantiated twice: the entry queue (clear on redirect) and the tag FIFO (never cleared except by rst).

Test Plan:
- Reset then 1-cycle memory latency, stall=0 → imem_addr 0x0,0x4,0x8…; out_pc_plus4 0x4,0x8,0xC in order with the matching rdata; steady throughput 1 instr/cycle after fill.
- stall held 10 cycles, latency 1 → queue fills to 4; imem_req drops to 0; out_instr stays 1st word; release → 4 entries drain in order with no loss.
- Latency 3, MAX_OUT=2 → outstanding never exceeds 2; imem_req low when 2 in flight.
- Redirect to 0x0000_0040 with 2 requests outstanding → next imem_addr=0x40; both old responses discarded; first out_pc_plus4=0x44.
- Redirect in the same cycle as imem_rvalid, then a second redirect 1 cycle later → only responses to the newest target reach the output.
- Assert rst (low) while out_valid=1 and 1 outstanding → out_valid=0 and imem_req=0 immediately; after release, fetch restarts at RESET_PC.
